tm_run_ctrl: RTL and testbench
==============================

// Module: tm_run_ctrl
// PURPOSE
// Run sequencer for the Turing-machine step engine and its tape RAM.
// Per run: clears the tape, initialises the engine, and steps it one transition per clock.
// Stops on halt, tape-edge overflow or step-limit timeout.
// Then scans the tape to count non-blank cells (sigma) and presents step count and sigma to host logic.
// PARAMETERS
// TAPE_LEN   64          number of tape cells; tape_addr walks 0..TAPE_LEN-1
// POS_W      7           width of head position / tape address
// SYM_W      3           width of a tape symbol; 0 = blank
// CNT_W      40          width of step counter (holds 7,021,292,621 = 0x1a2806c4d)
// STEP_LIMIT 2**CNT_W-1  step count at which the run ends with TIMEOUT
// PORTS
// CLK_n        in   1      clock, rising edge
// rst          in   1      synchronous active-high reset
// start        in   1      1-cycle pulse; begins a run from IDLE or DONE
// abort        in   1      returns to IDLE from any state
// eng_halt     in   1      engine halt flag (registered in the engine)
// eng_pos      in   POS_W  engine head position
// eng_init     out  1      holds the engine in state A at START_POS
// eng_step_en  out  1      engine advances one transition on each edge where high
// tape_we      out  1      controller write to tape (CLEAR only)
// tape_addr    out  POS_W  controller tape address (CLEAR/SCAN)
// tape_wdata   out  SYM_W  always 0
// tape_rdata   in   SYM_W  asynchronous read of tape[tape_addr]
// busy         out  1      high in CLEAR, RUN, SCAN
// done         out  1      high in DONE
// status       out  2      0 NONE/ABORT, 1 HALTED, 2 OVERFLOW, 3 TIMEOUT
// step_count   out  CNT_W  transitions executed in the last run
// sigma        out  POS_W  non-blank cells after the last run
// BEHAVIOUR
// - Reset state: IDLE.
//   - Outputs: eng_init=1, eng_step_en=0, tape_we=0, tape_addr=0, busy=0, done=0, status=0, step_count=0, sigma=0.
// - FSM states: IDLE, CLEAR, RUN, SCAN, DONE. All outputs are registered.
// - IDLE/DONE + start -> CLEAR.
//   - On the same edge: step_count=0, sigma=0, status=0, tape_addr=0.
// - CLEAR: tape_we=1, eng_init=1; tape_addr increments each cycle.
//   - After tape_addr=TAPE_LEN-1 is written -> RUN.
//   - CLEAR lasts exactly TAPE_LEN cycles.
// - RUN: eng_init=0, eng_step_en=1, tape_we=0. Stop conditions are evaluated on every edge:
//   - eng_halt=1 -> status HALTED. The counter does not increment on this edge.
//   - else eng_pos==0 or eng_pos==TAPE_LEN-1 -> status OVERFLOW. The counter does not increment.
//   - else step_count==STEP_LIMIT -> status TIMEOUT.
//   - else step_count++.
//   - Priority when several hold on one edge: HALTED > OVERFLOW > TIMEOUT.
//   - On any stop: eng_step_en=0 from the next cycle, tape_addr=0 -> SCAN.
// - SCAN: tape_we=0; tape_addr increments each cycle.
//   - sigma += (tape_rdata!=0) on each edge.
//   - After addr TAPE_LEN-1 is sampled -> DONE. SCAN lasts TAPE_LEN cycles.
// - DONE: done=1. status, step_count and sigma are held until the next start.
//   - start in DONE is a restart.
// - abort (any state except IDLE): -> IDLE next edge.
//   - status=0, done=0, eng_step_en=0, tape_we=0.
//   - step_count and sigma are frozen at their current values.
//   - abort has priority over start and over stop conditions.
// - start while busy: ignored.
// - rst mid-run: identical to reset; a partially cleared tape is not restored.
// - step_count saturates at STEP_LIMIT. No wrap is permitted.
// - Latency: start to first eng_step_en = TAPE_LEN+1 cycles.
// TESTING
// T1 TAPE_LEN=64, stub engine raises eng_halt after 5 step_en edges, tape holds 3 nonzero cells:
//    -> done, status=1, step_count=5, sigma=3; total start->done = 64+6+64 cycles.
// T2 Real engine, 2-state 5-symbol machine, STEP_LIMIT=1000:
//    -> status=3, step_count=1000, eng_step_en low the cycle after.
// T3 Stub drives eng_pos=0 on step 7 with eng_halt=1 on the same edge:
//    -> status=1 (HALTED wins), step_count=6.
// T4 abort asserted in CLEAR at tape_addr=20:
//    -> IDLE next cycle, tape_we=0, status=0, done=0; a later start clears all 64 cells.
// T5 start pulsed during RUN -> ignored; start in DONE -> CLEAR, step_count and sigma zeroed.
// T6 rst during SCAN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/tm_run_ctrl_if.sv
// Host/engine/tape signal bundle for the Turing-machine run sequencer.
interface tm_run_ctrl_if #(
  parameter int POS_W = 7,
  parameter int SYM_W = 3,
  parameter int CNT_W = 40
) ();
  logic             start;
  logic             abort;
  logic             eng_halt;
  logic [POS_W-1:0] eng_pos;
  logic             eng_init;
  logic             eng_step_en;
  logic             tape_we;
  logic [POS_W-1:0] tape_addr;
  logic [SYM_W-1:0] tape_wdata;
  logic [SYM_W-1:0] tape_rdata;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic [CNT_W-1:0] step_count;
  logic [POS_W-1:0] sigma;

  // Host, engine and tape side.
  modport master (
    output start, abort, eng_halt, eng_pos, tape_rdata,
    input  eng_init, eng_step_en, tape_we, tape_addr, tape_wdata,
           busy, done, status, step_count, sigma
  );

  // Sequencer side.
  modport slave (
    input  start, abort, eng_halt, eng_pos, tape_rdata,
    output eng_init, eng_step_en, tape_we, tape_addr, tape_wdata,
           busy, done, status, step_count, sigma
  );
endinterface

// File: rtl/tm_run_ctrl.sv
// Run sequencer: clears the tape, steps the engine until halt, tape-edge
// overflow or step-limit timeout, then scans the tape to count non-blank cells.
module tm_run_ctrl #(
  parameter int               TAPE_LEN   = 64,
  parameter int               POS_W      = 7,
  parameter int               SYM_W      = 3,
  parameter int               CNT_W      = 40,
  parameter logic [CNT_W-1:0] STEP_LIMIT = '1
) (
  input  logic          CLK_n,
  input  logic          rst,
  tm_run_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SCAN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE     = 2'd0,
    ST_HALTED   = 2'd1,
    ST_OVERFLOW = 2'd2,
    ST_TIMEOUT  = 2'd3
  } status_t;

  localparam logic [POS_W-1:0] LAST_ADDR = POS_W'(TAPE_LEN - 1);

  state_t           state_q, state_d;
  status_t          status_q, status_d;
  logic [POS_W-1:0] tape_addr_q, tape_addr_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic [POS_W-1:0] sigma_q, sigma_d;
  logic             eng_init_q, eng_init_d;
  logic             eng_step_en_q, eng_step_en_d;
  logic             tape_we_q, tape_we_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic addr_last;
  logic run_halt;
  logic run_ovf;
  logic run_tmo;
  logic run_stop;

  // Stop-condition decode; priority HALTED > OVERFLOW > TIMEOUT is applied where used.
  always_comb begin
    addr_last = (tape_addr_q == LAST_ADDR);
    run_halt  = bus.eng_halt;
    run_ovf   = (bus.eng_pos == '0) || (bus.eng_pos == LAST_ADDR);
    run_tmo   = (step_count_q == STEP_LIMIT);
    run_stop  = run_halt || run_ovf || run_tmo;
  end

  // State register.
  always_ff @(posedge CLK_n) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything, start only acts from IDLE/DONE.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (bus.start) state_d = S_CLEAR;
        S_CLEAR:        if (addr_last) state_d = S_RUN;
        S_RUN:          if (run_stop)  state_d = S_SCAN;
        S_SCAN:         if (addr_last) state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Output/datapath next values; control outputs are decoded from state_d so
  // that they are registered yet aligned with the state they belong to.
  always_comb begin
    eng_init_d    = (state_d == S_IDLE) || (state_d == S_CLEAR);
    eng_step_en_d = (state_d == S_RUN);
    tape_we_d     = (state_d == S_CLEAR);
    busy_d        = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_SCAN);
    done_d        = (state_d == S_DONE);

    status_d      = status_q;
    tape_addr_d   = tape_addr_q;
    step_count_d  = step_count_q;
    sigma_d       = sigma_q;

    if (bus.abort) begin
      // step_count and sigma stay frozen for post-mortem inspection.
      status_d    = ST_NONE;
      tape_addr_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            status_d     = ST_NONE;
            tape_addr_d  = '0;
            step_count_d = '0;
            sigma_d      = '0;
          end
        end
        S_CLEAR: begin
          tape_addr_d = addr_last ? '0 : tape_addr_q + POS_W'(1);
        end
        S_RUN: begin
          tape_addr_d = '0;
          if (run_halt) begin
            status_d = ST_HALTED;
          end else if (run_ovf) begin
            status_d = ST_OVERFLOW;
          end else if (run_tmo) begin
            status_d = ST_TIMEOUT;
          end else begin
            step_count_d = step_count_q + CNT_W'(1);
          end
        end
        S_SCAN: begin
          if (bus.tape_rdata != '0) begin
            sigma_d = sigma_q + POS_W'(1);
          end
          tape_addr_d = addr_last ? '0 : tape_addr_q + POS_W'(1);
        end
        default: begin
          tape_addr_d = '0;
        end
      endcase
    end
  end

  // Output and datapath registers.
  always_ff @(posedge CLK_n) begin
    if (rst) begin
      status_q      <= ST_NONE;
      tape_addr_q   <= '0;
      step_count_q  <= '0;
      sigma_q       <= '0;
      eng_init_q    <= 1'b1;
      eng_step_en_q <= 1'b0;
      tape_we_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      status_q      <= status_d;
      tape_addr_q   <= tape_addr_d;
      step_count_q  <= step_count_d;
      sigma_q       <= sigma_d;
      eng_init_q    <= eng_init_d;
      eng_step_en_q <= eng_step_en_d;
      tape_we_q     <= tape_we_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.eng_init    = eng_init_q;
  assign bus.eng_step_en = eng_step_en_q;
  assign bus.tape_we     = tape_we_q;
  assign bus.tape_addr   = tape_addr_q;
  assign bus.tape_wdata  = {SYM_W{1'b0}};
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.status      = status_q;
  assign bus.step_count  = step_count_q;
  assign bus.sigma       = sigma_q;

endmodule

// File: tb/tb_tm_run_ctrl.sv
// Bench for tm_run_ctrl: stub engine + tape RAM, table of full runs and
// hand-written sequences for abort, restart, reset and timeout corners.
module tb_tm_run_ctrl;

  localparam int NONE = 1000000;

  logic CLK_n;
  logic rst;

  tm_run_ctrl_if #(.POS_W(7), .SYM_W(3), .CNT_W(40)) ctrl_if ();

  tm_run_ctrl #(
    .TAPE_LEN  (64),
    .POS_W     (7),
    .SYM_W     (3),
    .CNT_W     (40),
    .STEP_LIMIT(40'd1000)
  ) dut (
    .CLK_n(CLK_n),
    .rst  (rst),
    .bus  (ctrl_if.slave)
  );

  initial CLK_n = 1'b0;
  always #5 CLK_n = ~CLK_n;

  // Stub engine and tape model.
  logic [2:0] tape [64];
  int         steps;
  int         halt_after;
  int         ovf_after;
  logic [6:0] ovf_pos;
  int         nz_cells;
  logic       fill_req;

  always @(posedge CLK_n) begin
    if (fill_req) begin
      for (int i = 0; i < 64; i++) tape[i] <= 3'd7;
    end else if (ctrl_if.tape_we) begin
      tape[ctrl_if.tape_addr[5:0]] <= ctrl_if.tape_wdata;
    end
    if (ctrl_if.eng_init) begin
      steps <= 0;
    end else if (ctrl_if.eng_step_en) begin
      if (steps < nz_cells) tape[6'(20 + steps)] <= 3'(steps + 1);
      steps <= steps + 1;
    end
  end

  assign ctrl_if.eng_halt   = (steps >= halt_after);
  assign ctrl_if.eng_pos    = (steps >= ovf_after) ? ovf_pos : 7'd32;
  assign ctrl_if.tape_rdata = tape[ctrl_if.tape_addr[5:0]];

  int n_vec;
  int n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_eng_init"},   64'(ctrl_if.eng_init),    64'd1);
    chk({tag, "_step_en"},    64'(ctrl_if.eng_step_en), 64'd0);
    chk({tag, "_tape_we"},    64'(ctrl_if.tape_we),     64'd0);
    chk({tag, "_tape_addr"},  64'(ctrl_if.tape_addr),   64'd0);
    chk({tag, "_busy"},       64'(ctrl_if.busy),        64'd0);
    chk({tag, "_done"},       64'(ctrl_if.done),        64'd0);
    chk({tag, "_status"},     64'(ctrl_if.status),      64'd0);
    chk({tag, "_step_count"}, 64'(ctrl_if.step_count),  64'd0);
    chk({tag, "_sigma"},      64'(ctrl_if.sigma),       64'd0);
  endtask

  task automatic tick();
    @(posedge CLK_n);
    #1;
  endtask

  task automatic pulse_start();
    ctrl_if.start = 1'b1;
    tick();
    ctrl_if.start = 1'b0;
  endtask

  task automatic prefill();
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
  endtask

  task automatic set_stub(input int h, input int o, input logic [6:0] p, input int nz);
    halt_after = h;
    ovf_after  = o;
    ovf_pos    = p;
    nz_cells   = nz;
  endtask

  // Cycles counted from the edge after the start edge until done is seen.
  task automatic wait_done(input string name, input int limit, output int n);
    n = 0;
    while (ctrl_if.done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    n_vec++;
    if (ctrl_if.done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_done_wait: done=%b after %0d cycles, want 1", name, ctrl_if.done, n);
    end
  endtask

  typedef struct {
    string      name;
    int         halt_after;
    int         ovf_after;
    logic [6:0] ovf_pos;
    int         nz;
    logic [1:0] exp_status;
    longint     exp_count;
    int         exp_sigma;
    int         exp_cycles;
  } vec_t;

  vec_t tbl [6];
  int   n;

  initial begin
    n_vec = 0;
    n_bad = 0;
    ctrl_if.start = 1'b0;
    ctrl_if.abort = 1'b0;
    fill_req = 1'b0;
    set_stub(NONE, NONE, 7'd0, 0);
    rst = 1'b1;

    tbl[0] = '{"halt5",      5,    NONE, 7'd0,  3, 2'd1, 5,    3, 134};
    tbl[1] = '{"halt_ovf6",  6,    6,    7'd0,  2, 2'd1, 6,    2, 135};
    tbl[2] = '{"ovf_pos0",   NONE, 3,    7'd0,  1, 2'd2, 3,    1, 132};
    tbl[3] = '{"halt0",      0,    NONE, 7'd0,  0, 2'd1, 0,    0, 129};
    tbl[4] = '{"ovf_pos63",  5,    4,    7'd63, 4, 2'd2, 4,    4, 133};
    tbl[5] = '{"timeout",    NONE, NONE, 7'd0,  4, 2'd3, 1000, 4, 1129};

    repeat (3) tick();
    rst = 1'b0;
    chk_reset("reset");

    // Full runs from a garbage-filled tape.
    for (int v = 0; v < 6; v++) begin
      prefill();
      set_stub(tbl[v].halt_after, tbl[v].ovf_after, tbl[v].ovf_pos, tbl[v].nz);
      pulse_start();
      wait_done(tbl[v].name, 3000, n);
      chk({tbl[v].name, "_cycles"},     64'(n),                  64'(tbl[v].exp_cycles));
      chk({tbl[v].name, "_status"},     64'(ctrl_if.status),     64'(tbl[v].exp_status));
      chk({tbl[v].name, "_step_count"}, 64'(ctrl_if.step_count), 64'(tbl[v].exp_count));
      chk({tbl[v].name, "_sigma"},      64'(ctrl_if.sigma),      64'(tbl[v].exp_sigma));
      chk({tbl[v].name, "_busy"},       64'(ctrl_if.busy),       64'd0);
      chk({tbl[v].name, "_step_en"},    64'(ctrl_if.eng_step_en), 64'd0);
    end

    // Timeout: counter saturates at the limit, step enable drops with the stop.
    prefill();
    set_stub(NONE, NONE, 7'd0, 0);
    pulse_start();
    n = 0;
    while (ctrl_if.status == 2'd0 && n < 1300) begin
      tick();
      n++;
    end
    chk("tmo_status",     64'(ctrl_if.status),      64'd3);
    chk("tmo_step_count", 64'(ctrl_if.step_count),  64'd1000);
    chk("tmo_step_en",    64'(ctrl_if.eng_step_en), 64'd0);
    chk("tmo_busy",       64'(ctrl_if.busy),        64'd1);
    tick();
    chk("tmo_count_hold", 64'(ctrl_if.step_count),  64'd1000);
    wait_done("tmo", 200, n);

    // Abort in CLEAR at address 20, then a clean run must clear every cell.
    prefill();
    set_stub(5, NONE, 7'd0, 3);
    pulse_start();
    n = 0;
    while (ctrl_if.tape_addr != 7'd20 && n < 100) begin
      tick();
      n++;
    end
    chk("abort_clr_addr", 64'(ctrl_if.tape_addr), 64'd20);
    ctrl_if.abort = 1'b1;
    tick();
    ctrl_if.abort = 1'b0;
    chk("abort_clr_busy",     64'(ctrl_if.busy),     64'd0);
    chk("abort_clr_tape_we",  64'(ctrl_if.tape_we),  64'd0);
    chk("abort_clr_status",   64'(ctrl_if.status),   64'd0);
    chk("abort_clr_done",     64'(ctrl_if.done),     64'd0);
    chk("abort_clr_eng_init", 64'(ctrl_if.eng_init), 64'd1);
    repeat (2) tick();
    chk("abort_clr_idle", 64'(ctrl_if.busy), 64'd0);
    pulse_start();
    wait_done("reclear", 400, n);
    chk("reclear_cycles", 64'(n),                  64'd134);
    chk("reclear_sigma",  64'(ctrl_if.sigma),      64'd3);
    chk("reclear_status", 64'(ctrl_if.status),     64'd1);

    // Abort in RUN freezes the step counter.
    prefill();
    set_stub(NONE, NONE, 7'd0, 0);
    pulse_start();
    n = 0;
    while (ctrl_if.step_count != 40'd10 && n < 200) begin
      tick();
      n++;
    end
    ctrl_if.abort = 1'b1;
    tick();
    ctrl_if.abort = 1'b0;
    chk("abort_run_count",   64'(ctrl_if.step_count),  64'd10);
    chk("abort_run_status",  64'(ctrl_if.status),      64'd0);
    chk("abort_run_step_en", 64'(ctrl_if.eng_step_en), 64'd0);
    chk("abort_run_busy",    64'(ctrl_if.busy),        64'd0);
    tick();
    chk("abort_run_frozen",  64'(ctrl_if.step_count),  64'd10);

    // Start latency, start ignored while running, restart from DONE.
    prefill();
    set_stub(5, NONE, 7'd0, 3);
    ctrl_if.start = 1'b1;
    tick();
    ctrl_if.start = 1'b0;
    n = 1;
    while (ctrl_if.eng_step_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'd65);
    pulse_start();
    chk("start_in_run_busy", 64'(ctrl_if.eng_step_en), 64'd1);
    wait_done("start_in_run", 400, n);
    chk("start_in_run_status", 64'(ctrl_if.status),     64'd1);
    chk("start_in_run_count",  64'(ctrl_if.step_count), 64'd5);
    chk("start_in_run_sigma",  64'(ctrl_if.sigma),      64'd3);
    pulse_start();
    chk("restart_count",   64'(ctrl_if.step_count), 64'd0);
    chk("restart_sigma",   64'(ctrl_if.sigma),      64'd0);
    chk("restart_status",  64'(ctrl_if.status),     64'd0);
    chk("restart_done",    64'(ctrl_if.done),       64'd0);
    chk("restart_busy",    64'(ctrl_if.busy),       64'd1);
    chk("restart_tape_we", 64'(ctrl_if.tape_we),    64'd1);

    // Reset in the middle of SCAN.
    n = 0;
    while (!(ctrl_if.busy && ctrl_if.status != 2'd0) && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("pre_rst_in_scan", 64'(ctrl_if.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_scan");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
